// File: rtl/if_prefetch_queue.sv
// Instruction-fetch front end: owns the fetch PC and buffers up to DEPTH
// fetched {instr, pc} entries so ID stalls do not block memory fetches.
module if_prefetch_queue #(
  parameter int          DATA_W  = 16,
  parameter int          ADDR_W  = 16,
  parameter int          DEPTH   = 4,
  parameter logic [3:0]  HLT_OPC = 4'hF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         redirect,
  input  logic [ADDR_W-1:0]            redirect_pc,
  output logic                         imem_req,
  output logic [ADDR_W-1:0]            imem_addr,
  input  logic [DATA_W-1:0]            imem_data,
  input  logic                         deq,
  output logic                         out_valid,
  output logic [DATA_W-1:0]            out_instr,
  output logic [ADDR_W-1:0]            out_pc,
  output logic [ADDR_W-1:0]            out_pc_next,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         halted
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(DATA_W/8);

  logic [DATA_W-1:0] instr_q [DEPTH];
  logic [ADDR_W-1:0] pc_q    [DEPTH];
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] inflight_pc;
  logic              inflight;

  logic [CW:0]       pending;
  logic              enq;
  logic              do_deq;
  logic              is_hlt;

  // The in-flight read reserves a slot, so the queue can never overflow.
  assign pending   = {1'b0, count} + (CW+1)'(inflight);
  assign imem_req  = !rst && !halted && !redirect && (pending < (CW+1)'(DEPTH));
  assign imem_addr = fetch_pc;

  assign is_hlt    = (imem_data[DATA_W-1 -: 4] == HLT_OPC);
  assign enq       = inflight && !halted;
  assign do_deq    = deq && out_valid;

  assign out_valid   = (count != '0);
  assign out_instr   = instr_q[head];
  assign out_pc      = pc_q[head];
  assign out_pc_next = out_valid ? out_pc + STEP : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= '0;
      inflight_pc <= '0;
      inflight    <= 1'b0;
      halted      <= 1'b0;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
      end
    end else if (redirect) begin
      // Flush discards the queue, any in-flight read and a pending halt.
      fetch_pc <= redirect_pc;
      inflight <= 1'b0;
      halted   <= 1'b0;
      head     <= tail;
      count    <= '0;
    end else begin
      inflight <= imem_req;
      if (imem_req) begin
        fetch_pc    <= fetch_pc + STEP;
        inflight_pc <= fetch_pc;
      end
      if (enq) begin
        instr_q[tail] <= imem_data;
        pc_q[tail]    <= inflight_pc;
        tail          <= tail + 1'b1;
        if (is_hlt)
          halted <= 1'b1;
      end
      if (do_deq)
        head <= head + 1'b1;
      if (enq && !do_deq)
        count <= count + 1'b1;
      else if (!enq && do_deq)
        count <= count - 1'b1;
    end
  end

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Self-checking bench: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_if_prefetch_queue;

  localparam int DW    = 16;
  localparam int AW    = 16;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, redirect, deq;
  logic [AW-1:0] redirect_pc;
  logic [DW-1:0] imem_data;
  logic          imem_req, out_valid, halted;
  logic [AW-1:0] imem_addr, out_pc, out_pc_next;
  logic [DW-1:0] out_instr;
  logic [CW-1:0] count;

  if_prefetch_queue #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .HLT_OPC(4'hF)) dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_data(imem_data),
    .deq(deq), .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
    .out_pc_next(out_pc_next), .count(count), .halted(halted)
  );

  typedef struct packed {
    logic [DW-1:0] instr;
    logic [AW-1:0] pc;
  } entry_t;

  entry_t        q[$];
  logic [AW-1:0] m_fetch_pc, m_inflight_pc;
  bit            m_inflight, m_halted;
  logic [AW-1:0] hlt_addr;
  bit            prev_req;
  logic [AW-1:0] prev_addr;
  int            tests, fails;
  bit            chk_en;

  logic          s_req, s_valid, s_halted;
  logic [AW-1:0] s_addr, s_pc, s_pcn;
  logic [DW-1:0] s_instr;
  logic [CW-1:0] s_count;

  function automatic logic [DW-1:0] word(input logic [AW-1:0] a);
    if (a == hlt_addr) return 16'hF000;
    return 16'h1000 + DW'(a >> 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, sample, compare to model, advance model.
  task automatic cyc(input bit r, input bit rd, input logic [AW-1:0] rpc, input bit d);
    bit            e_req;
    logic [AW-1:0] e_pcn;
    @(negedge clk);
    rst = r; redirect = rd; redirect_pc = rpc; deq = d;
    imem_data = prev_req ? word(prev_addr) : DW'($urandom);
    #1;
    s_req = imem_req; s_addr = imem_addr; s_valid = out_valid; s_halted = halted;
    s_pc = out_pc; s_pcn = out_pc_next; s_instr = out_instr; s_count = count;

    e_req = !r && !m_halted && !rd && (q.size() + int'(m_inflight) < DEPTH);
    if (chk_en) begin
      chk("imem_req", s_req, e_req);
      chk("imem_addr", s_addr, m_fetch_pc);
      chk("count", s_count, q.size());
      chk("out_valid", s_valid, q.size() != 0);
      chk("halted", s_halted, m_halted);
      if (q.size() != 0) begin
        e_pcn = q[0].pc + AW'(2);
        chk("out_instr", s_instr, q[0].instr);
        chk("out_pc", s_pc, q[0].pc);
        chk("out_pc_next", s_pcn, e_pcn);
      end
    end
    prev_req = s_req; prev_addr = s_addr;

    if (r) begin
      q.delete(); m_fetch_pc = '0; m_inflight = 0; m_halted = 0;
    end else if (rd) begin
      q.delete(); m_fetch_pc = rpc; m_inflight = 0; m_halted = 0;
    end else begin
      if (d && q.size() > 0) void'(q.pop_front());
      if (m_inflight && !m_halted) begin
        q.push_back({imem_data, m_inflight_pc});
        if (imem_data[DW-1 -: 4] == 4'hF) m_halted = 1;
      end
      if (e_req) begin
        m_inflight_pc = m_fetch_pc;
        m_fetch_pc    = m_fetch_pc + AW'(2);
      end
      m_inflight = e_req;
    end
  endtask

  initial begin
    int            nreq, maxc;
    logic [AW-1:0] rpc;
    bit            rd, d, r;
    rst = 1; redirect = 0; deq = 0; redirect_pc = '0; imem_data = '0;
    hlt_addr = 16'hFFFF; m_fetch_pc = '0; m_inflight_pc = '0;
    m_inflight = 0; m_halted = 0; prev_req = 0; prev_addr = '0;
    tests = 0; fails = 0; chk_en = 0;

    cyc(1, 0, 16'h0, 0);
    chk("rst_req_low", s_req, 0);
    chk_en = 1;
    cyc(1, 0, 16'h0, 0);

    // Streaming with deq held high
    cyc(0, 0, 16'h0, 1);
    chk("first_req", s_req, 1);
    chk("first_addr", s_addr, 16'h0000);
    chk("rst_valid", s_valid, 0);
    chk("rst_count", s_count, 0);
    chk("rst_halted", s_halted, 0);
    chk("rst_instr", s_instr, 16'h0000);
    chk("rst_pc", s_pc, 16'h0000);
    chk("rst_pc_next", s_pcn, 16'h0000);
    cyc(0, 0, 16'h0, 1);
    cyc(0, 0, 16'h0, 1);
    chk("stream_valid0", s_valid, 1);
    chk("stream_pc0", s_pc, 16'h0000);
    chk("stream_instr0", s_instr, 16'h1000);
    cyc(0, 0, 16'h0, 1);
    chk("stream_pc1", s_pc, 16'h0002);
    chk("stream_instr1", s_instr, 16'h1001);
    maxc = 0;
    repeat (8) begin
      cyc(0, 0, 16'h0, 1);
      if (int'(s_count) > maxc) maxc = int'(s_count);
    end
    chk("stream_max_count", maxc, 1);

    // Fill with deq low, then release one slot
    cyc(1, 0, 16'h0, 0);
    nreq = 0;
    repeat (10) begin
      cyc(0, 0, 16'h0, 0);
      nreq += int'(s_req);
    end
    chk("fill_reqs", nreq, 4);
    chk("fill_count", s_count, 4);
    chk("fill_req_off", s_req, 0);
    cyc(0, 0, 16'h0, 1);
    cyc(0, 0, 16'h0, 0);
    chk("refill_req", s_req, 1);
    chk("refill_addr", s_addr, 16'h0008);

    // Reset with queue holding entries and a read in flight
    cyc(1, 0, 16'h0, 0);
    cyc(0, 0, 16'h0, 0);
    chk("mrst_count", s_count, 0);
    chk("mrst_valid", s_valid, 0);
    chk("mrst_halted", s_halted, 0);
    chk("mrst_addr", s_addr, 16'h0000);
    chk("mrst_req", s_req, 1);

    // Redirect with count=3 and inflight=1
    repeat (3) cyc(0, 0, 16'h0, 0);
    cyc(0, 1, 16'h0040, 0);
    chk("pre_redir_count", s_count, 3);
    cyc(0, 0, 16'h0, 0);
    chk("redir_count", s_count, 0);
    chk("redir_req", s_req, 1);
    chk("redir_addr", s_addr, 16'h0040);
    cyc(0, 0, 16'h0, 0);
    cyc(0, 0, 16'h0, 0);
    chk("redir_valid", s_valid, 1);
    chk("redir_pc", s_pc, 16'h0040);
    chk("redir_instr", s_instr, 16'h1020);

    // Halt at address 6
    hlt_addr = 16'h0006;
    cyc(1, 0, 16'h0, 1);
    repeat (5) cyc(0, 0, 16'h0, 1);
    cyc(0, 0, 16'h0, 1);
    chk("hlt_halted", s_halted, 1);
    chk("hlt_pc", s_pc, 16'h0006);
    chk("hlt_instr", s_instr, 16'hF000);
    chk("hlt_req", s_req, 0);
    nreq = 0;
    repeat (5) begin
      cyc(0, 0, 16'h0, 1);
      nreq += int'(s_req);
    end
    chk("hlt_no_reqs", nreq, 0);
    chk("hlt_drained", s_count, 0);
    hlt_addr = 16'hFFFF;
    cyc(0, 1, 16'h0000, 0);
    cyc(0, 0, 16'h0, 0);
    chk("unhalt", s_halted, 0);
    chk("unhalt_req", s_req, 1);
    chk("unhalt_addr", s_addr, 16'h0000);

    // PC wrap
    cyc(0, 1, 16'hFFFE, 1);
    cyc(0, 0, 16'h0, 1);
    chk("wrap_addr", s_addr, 16'hFFFE);
    cyc(0, 0, 16'h0, 1);
    cyc(0, 0, 16'h0, 1);
    chk("wrap_pc0", s_pc, 16'hFFFE);
    chk("wrap_pcn0", s_pcn, 16'h0000);
    cyc(0, 0, 16'h0, 1);
    chk("wrap_pc1", s_pc, 16'h0000);
    cyc(0, 0, 16'h0, 1);
    chk("wrap_pc2", s_pc, 16'h0002);

    // Randomized traffic
    repeat (3000) begin
      r   = ($urandom_range(0, 199) == 0);
      rd  = ($urandom_range(0, 15) == 0);
      d   = ($urandom_range(0, 9) < 7);
      rpc = ($urandom_range(0, 7) == 0) ? 16'hFFF0 + 16'(2 * $urandom_range(0, 7))
                                        : {16'($urandom) >> 1, 1'b0};
      if (rd && !r)
        hlt_addr = ($urandom_range(0, 3) == 0) ? rpc + 16'(2 * $urandom_range(0, 12)) : 16'hFFFF;
      cyc(r, rd, rpc, d);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
